// File: rtl/param_shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : param_shift_reg
// Description : WIDTH-bit register with parallel load, shift/rotate/clear modes
//               and a burst sequencer. Optional parity output is enabled by
//               the PARAM_SHIFT_REG_PARITY_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
module param_shift_reg #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}},
  parameter int               CNT_W   = 4
) (
  input  logic             clk,
  input  logic             rst_async,
  input  logic             rst_sync,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  input  logic             start,
  input  logic [CNT_W-1:0] cnt,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
`ifdef PARAM_SHIFT_REG_PARITY_EN
  ,
  output logic             parity
`endif
);

  localparam logic [2:0] c_mode_load = 3'b001;
  localparam logic [2:0] c_mode_shl  = 3'b010;
  localparam logic [2:0] c_mode_shr  = 3'b011;
  localparam logic [2:0] c_mode_rol  = 3'b100;
  localparam logic [2:0] c_mode_ror  = 3'b101;
  localparam logic [2:0] c_mode_asr  = 3'b110;
  localparam logic [2:0] c_mode_clr  = 3'b111;

  localparam logic [CNT_W-1:0] c_cnt_zero = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] c_cnt_one  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_q;
  logic [CNT_W-1:0] r_rem;
  logic [2:0]       r_op;
  logic             r_busy;
  logic             r_done;

  logic [WIDTH-1:0] w_q_next;
  logic             w_shift_mode;
  logic             w_start_acc;

  function automatic logic [WIDTH-1:0] f_apply(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] cur,
    input logic             s,
    input logic [WIDTH-1:0] ld
  );
    logic [WIDTH-1:0] res;
    res = cur;
    case (op)
      c_mode_load: res = ld;
      c_mode_shl:  res = {cur[WIDTH-2:0], s};
      c_mode_shr:  res = {s, cur[WIDTH-1:1]};
      c_mode_rol:  res = {cur[WIDTH-2:0], cur[WIDTH-1]};
      c_mode_ror:  res = {cur[0], cur[WIDTH-1:1]};
      c_mode_asr:  res = {cur[WIDTH-1], cur[WIDTH-1:1]};
      c_mode_clr:  res = RST_VAL;
      default:     res = cur;
    endcase
    return res;
  endfunction

  // A start only launches a burst for the shift/rotate modes in IDLE.
  always_comb begin
    w_shift_mode = (mode >= c_mode_shl) && (mode <= c_mode_asr);
    w_start_acc  = (r_state == S_IDLE) && en && start && w_shift_mode;
  end

  always_comb begin
    w_q_next = r_q;
    if (rst_sync) begin
      w_q_next = RST_VAL;
    end else if (en) begin
      if (r_state == S_RUN) begin
        w_q_next = f_apply(r_op, r_q, sin, d);
      end else if (w_start_acc) begin
        if (cnt != c_cnt_zero) begin
          w_q_next = f_apply(mode, r_q, sin, d);
        end
      end else begin
        w_q_next = f_apply(mode, r_q, sin, d);
      end
    end
  end

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      r_state <= S_IDLE;
      r_q     <= RST_VAL;
      r_rem   <= c_cnt_zero;
      r_op    <= 3'b000;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_q    <= w_q_next;
      r_done <= 1'b0;
      if (rst_sync) begin
        r_state <= S_IDLE;
        r_rem   <= c_cnt_zero;
        r_busy  <= 1'b0;
      end else if (en) begin
        case (r_state)
          S_RUN: begin
            if (r_rem == c_cnt_one) begin
              r_rem   <= c_cnt_zero;
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_rem <= r_rem - c_cnt_one;
            end
          end
          default: begin
            if (w_start_acc) begin
              r_op <= mode;
              // Bursts of 0 or 1 shifts finish at the accepting edge.
              if (cnt <= c_cnt_one) begin
                r_done <= 1'b1;
              end else begin
                r_rem   <= cnt - c_cnt_one;
                r_state <= S_RUN;
                r_busy  <= 1'b1;
              end
            end
          end
        endcase
      end
    end
  end

  assign q    = r_q;
  assign busy = r_busy;
  assign done = r_done;

`ifdef PARAM_SHIFT_REG_PARITY_EN
  localparam logic c_rst_parity = ^RST_VAL;

  logic r_parity;

  // Tracks q exactly, so it follows the same hold/reset behaviour.
  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      r_parity <= c_rst_parity;
    end else begin
      r_parity <= ^w_q_next;
    end
  end

  assign parity = r_parity;
`endif

endmodule
`default_nettype wire

// File: tb/tb_param_shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_param_shift_reg
// Description : Self-checking bench for param_shift_reg (WIDTH=8, RST_VAL=A5).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_param_shift_reg;

  localparam logic [7:0] RV = 8'hA5;

  logic       clk = 1'b0;
  logic       rst_async, rst_sync, en, start, sin;
  logic [2:0] mode;
  logic [7:0] d;
  logic [3:0] cnt;
  logic [7:0] q;
  logic       busy, done;
`ifdef PARAM_SHIFT_REG_PARITY_EN
  logic       parity;
`endif

  int total = 0;
  int bad   = 0;

  // Reference state: expected q, shifts still owed by a burst, latched op.
  logic [7:0] eq;
  int         left;
  logic [2:0] bop;
  logic       edone;

  param_shift_reg #(
    .WIDTH  (8),
    .RST_VAL(RV),
    .CNT_W  (4)
  ) dut (
    .clk      (clk),
    .rst_async(rst_async),
    .rst_sync (rst_sync),
    .en       (en),
    .mode     (mode),
    .d        (d),
    .sin      (sin),
    .start    (start),
    .cnt      (cnt),
    .q        (q),
    .busy     (busy),
    .done     (done)
`ifdef PARAM_SHIFT_REG_PARITY_EN
    ,
    .parity   (parity)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] model_op(input logic [2:0] op, input logic [7:0] cur,
                                          input logic s, input logic [7:0] ld);
    int v;
    v = int'(cur);
    case (op)
      3'd0:    return cur;
      3'd1:    return ld;
      3'd2:    return 8'((v * 2 + int'(s)) % 256);
      3'd3:    return 8'(v / 2 + int'(s) * 128);
      3'd4:    return 8'((v * 2) % 256 + v / 128);
      3'd5:    return 8'(v / 2 + (v % 2) * 128);
      3'd6:    return 8'(v / 2 + (v / 128) * 128);
      default: return RV;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".q"}, q, eq);
    chk({tag, ".busy"}, {7'b0, busy}, {7'b0, (left > 0)});
    chk({tag, ".done"}, {7'b0, done}, {7'b0, edone});
`ifdef PARAM_SHIFT_REG_PARITY_EN
    chk({tag, ".parity"}, {7'b0, parity}, {7'b0, ^eq});
`endif
  endtask

  // Advance one edge with the current inputs, update the model, then check.
  task automatic step(input string tag);
    logic [7:0] nq;
    logic       nd;
    nq = eq;
    nd = 1'b0;
    if (rst_sync) begin
      nq   = RV;
      left = 0;
    end else if (en) begin
      if (left > 0) begin
        nq = model_op(bop, eq, sin, d);
        left--;
        if (left == 0) nd = 1'b1;
      end else if (start && mode >= 3'd2 && mode <= 3'd6) begin
        bop = mode;
        if (cnt == 4'd0) begin
          nd = 1'b1;
        end else begin
          nq   = model_op(mode, eq, sin, d);
          left = int'(cnt) - 1;
          if (left == 0) nd = 1'b1;
        end
      end else begin
        nq = model_op(mode, eq, sin, d);
      end
    end
    @(posedge clk);
    #1;
    eq    = nq;
    edone = nd;
    check_all(tag);
  endtask

  initial begin
    int edges;
    int nbusy;
    int seen;

    rst_async = 1'b1; rst_sync = 1'b0; en = 1'b0; start = 1'b0; sin = 1'b0;
    mode = 3'd0; d = 8'h00; cnt = 4'd0;
    eq = RV; left = 0; bop = 3'd0; edone = 1'b0;
    #2;
    check_all("reset_state");
    rst_async = 1'b0;

    // Mid-cycle asynchronous reset takes effect before the next edge.
    en = 1'b1; mode = 3'd1; d = 8'h3C;
    step("load3c");
    #2 rst_async = 1'b1;
    #1;
    eq = RV; left = 0; edone = 1'b0;
    check_all("async_mid");
    chk("async_mid_const", q, 8'hA5);
    rst_async = 1'b0;

    // Synchronous reset ignores en.
    step("load3c_again");
    rst_sync = 1'b1; en = 1'b0;
    step("sync_rst");
    chk("sync_rst_const", q, 8'hA5);
    rst_sync = 1'b0; en = 1'b1;

    // Rotate / arithmetic-shift sequence.
    mode = 3'd1; d = 8'h81; step("load81");
    mode = 3'd4; step("rol");  chk("rol_const", q, 8'h03);
    mode = 3'd5; step("ror");  chk("ror_const", q, 8'h81);
    mode = 3'd6; step("asr");  chk("asr_const", q, 8'hC0);

    // Five-shift SHL burst; mode changes during RUN must be ignored.
    mode = 3'd1; d = 8'h01; step("load01");
    mode = 3'd2; sin = 1'b0; start = 1'b1; cnt = 4'd5;
    step("burst_acc");
    start = 1'b0; mode = 3'd7;
    nbusy = busy ? 1 : 0;
    edges = 1;
    for (int i = 0; i < 12 && !done; i++) begin
      step("burst_run");
      edges++;
      if (busy) nbusy++;
    end
    chk("burst_done_seen", {7'b0, done}, 8'h01);
    chk("burst_q", q, 8'h20);
    chk("burst_busy_cycles", 8'(nbusy), 8'd4);
    chk("burst_done_edge", 8'(edges), 8'd5);
    mode = 3'd0;
    step("burst_done_clear");

    // Burst with en low for three cycles mid-way.
    mode = 3'd1; d = 8'h01; step("load01_b");
    mode = 3'd2; sin = 1'b1; start = 1'b1; cnt = 4'd5;
    step("frz_acc");
    start = 1'b0; mode = 3'd3;
    step("frz_run1");
    step("frz_run2");
    en = 1'b0;
    step("frz_hold1");
    step("frz_hold2");
    step("frz_hold3");
    en = 1'b1;
    edges = 6;
    for (int i = 0; i < 12 && !done; i++) begin
      step("frz_run");
      edges++;
    end
    chk("frz_done_edge", 8'(edges), 8'd8);
    chk("frz_q", q, 8'h3F);
    mode = 3'd0;

    // cnt=0: no shift, single done pulse, cleared even with en low.
    mode = 3'd2; start = 1'b1; cnt = 4'd0;
    step("cnt0");
    chk("cnt0_q", q, 8'h3F);
    start = 1'b0; en = 1'b0; mode = 3'd0;
    step("cnt0_clear");
    en = 1'b1;

    // start with LOAD is ignored and the load happens.
    mode = 3'd1; d = 8'h5A; start = 1'b1; cnt = 4'd3;
    step("start_load");
    chk("start_load_q", q, 8'h5A);
    start = 1'b0; mode = 3'd0;

    // Synchronous reset aborts a running burst with no done pulse.
    mode = 3'd3; start = 1'b1; cnt = 4'd9; sin = 1'b0;
    step("abort_acc");
    start = 1'b0; mode = 3'd0;
    step("abort_run1");
    step("abort_run2");
    step("abort_run3");
    rst_sync = 1'b1;
    step("abort_rst");
    chk("abort_q", q, 8'hA5);
    rst_sync = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      step("abort_after");
      if (done) seen++;
    end
    chk("abort_no_done", 8'(seen), 8'd0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      rst_sync = ($urandom_range(0, 39) == 0);
      en       = ($urandom_range(0, 7) != 0);
      mode     = 3'($urandom_range(0, 7));
      start    = ($urandom_range(0, 2) == 0);
      cnt      = 4'($urandom_range(0, 15));
      sin      = 1'($urandom_range(0, 1));
      d        = 8'($urandom_range(0, 255));
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/param_shift_reg.md
Name: param_shift_reg

Overview:
- Parametrised WIDTH-bit register with the same reset model as the single-bit D flip-flop: async reset, sync reset, clock enable.
- Adds a parallel load, seven shift/rotate/clear modes, and a burst sequencer that performs N shifts from one start command.
- Used as the general-purpose storage, serializer and barrel-step element in datapath and serial-interface blocks.

Parameters:
- WIDTH, 8, register width in bits; legal range 2..64.
- RST_VAL, {WIDTH{1'b0}}, value loaded into q by rst_async, by rst_sync and by mode CLR.
- CNT_W, 4, width of the burst count input; bursts of 0..2^CNT_W-1 shifts.

Ports:
- clk  in  1  rising-edge clock.
- rst_async  in  1  asynchronous active-high reset; highest priority.
- rst_sync  in  1  synchronous active-high reset; takes effect at the clk edge and ignores en.
- en  in  1  clock enable; when low, q and the FSM hold their state.
- mode  in  3  operation select, decoded below.
- d  in  WIDTH  parallel load data.
- sin  in  1  serial input for SHL and SHR.
- start  in  1  request a burst of cnt shifts using the current mode.
- cnt  in  CNT_W  burst length.
- q  out  WIDTH  register contents.
- busy  out  1  high while a burst is in progress.
- done  out  1  single-cycle pulse marking burst completion.

Behaviour:
- Reset:
  - rst_async sets q=RST_VAL, busy=0, done=0, remaining=0 and FSM=IDLE immediately, without waiting for clk.
  - rst_sync produces the same state at the next edge, regardless of en, start or FSM state. A burst in progress is aborted and done is not pulsed.
- Priority at each edge: rst_sync, then en=0 (hold), then FSM RUN, then an accepted start, then mode.
- Mode decode:
  - 000 HOLD: no change.
  - 001 LOAD: q=d.
  - 010 SHL: q={q[W-2:0],sin}.
  - 011 SHR: q={sin,q[W-1:1]}.
  - 100 ROL: q={q[W-2:0],q[W-1]}.
  - 101 ROR: q={q[0],q[W-1:1]}.
  - 110 ASR: q={q[W-1],q[W-1:1]}.
  - 111 CLR: q=RST_VAL.
- Single-step operation: in IDLE with en=1 and start=0 (or start with a non-shift mode), the mode is applied once per edge. Start is ignored for modes 000, 001 and 111, and the mode is applied normally.
- Burst start: start is accepted in IDLE with en=1 and mode in 010..110.
  - The mode is latched into op_r; mode input changes afterwards have no effect on the burst.
  - cnt=0: q is unchanged, done=1 on the next cycle, FSM stays IDLE.
  - cnt=1: one shift at the accepting edge, done=1 on the next cycle, FSM stays IDLE.
  - cnt>=2: one shift at the accepting edge, remaining=cnt-1, FSM goes to RUN, busy=1.
- RUN state:
  - Each edge with en=1 performs an op_r shift and decrements remaining.
  - The edge that makes remaining 0 performs the final shift, returns FSM to IDLE, clears busy and sets done.
  - start and mode are ignored in RUN.
  - en=0 freezes q, remaining and busy; the burst resumes when en returns to 1.
- Shift count: a burst always performs exactly cnt shifts, counted as edges with en=1.
- done timing: done is registered and high for exactly one clk cycle. It clears at the following edge regardless of en.
- Serial input: SHL and SHR sample sin at each shifting edge, including during a burst.
- Latency: q updates one edge after the command is accepted. busy and done are registered, never combinational from inputs.

Optional Feature:
- Macro: PARAM_SHIFT_REG_PARITY_EN.
- When defined:
  - Adds output parity (1 bit) = registered XOR-reduction of the next value of q, updated on the same edge as q.
  - Reset value of parity is ^RST_VAL.
  - parity holds whenever q holds.
- When undefined: the parity port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset checks (WIDTH=8, RST_VAL=8'hA5):
  - Assert rst_async mid-cycle → q=8'hA5 immediately, before the next edge.
  - LOAD 8'h3C, then rst_sync=1 with en=0 → q=8'hA5 at the next edge.
- LOAD 8'h81, then one edge each of ROL, ROR and ASR → q=8'h03, then 8'h81, then 8'hC0.
- Burst: q=8'h01, mode=SHL, sin=0, start with cnt=5:
  - busy high for 4 cycles; q=8'h20 after 5 shifting edges.
  - done pulses exactly one cycle, the cycle after the last shift.
- Burst with en dropped low for 3 cycles mid-burst: q, busy and remaining frozen; total shifts still 5; done is delayed by 3 cycles.
- Burst edge cases:
  - start with cnt=0 → q unchanged, busy never high, done pulses once.
  - start with mode=LOAD → start ignored, q=d.
- rst_sync asserted during RUN → q=RST_VAL, busy=0, and no done pulse is ever produced for that burst.
